// File: rtl/hack_pkg.sv
// Hack CPU shared definitions: instruction fields,
// ALU control bundle and word widths.
package hack_pkg;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 15;

  localparam int BIT_C   = 15;
  localparam int BIT_A   = 12;
  localparam int CMP_HI  = 11;
  localparam int CMP_LO  = 6;

  localparam int BIT_DA  = 5;
  localparam int BIT_DD  = 4;
  localparam int BIT_DM  = 3;

  localparam int BIT_JLT = 2;
  localparam int BIT_JEQ = 1;
  localparam int BIT_JGT = 0;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

endpackage

// File: rtl/PC.sv
// Hack program counter: reset beats load,
// load beats increment.
module PC (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        inc,
  output logic [15:0] out
);

  always_ff @(posedge clk) begin
    if (reset)
      out <= '0;
    else if (load)
      out <= in;
    else if (inc)
      out <= out + 16'd1;
  end

endmodule

// File: rtl/hack_alu.sv
// Hack ALU: conditioned x/y operands, add or and,
// optional output negate, zero and negative flags.
module hack_alu
  import hack_pkg::*;
(
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  alu_ctrl_t        ctrl,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);

  logic [WIDTH-1:0] xz;
  logic [WIDTH-1:0] xc;
  logic [WIDTH-1:0] yz;
  logic [WIDTH-1:0] yc;
  logic [WIDTH-1:0] res;

  always_comb begin
    xz  = ctrl.zx ? '0 : x;
    xc  = ctrl.nx ? ~xz : xz;
    yz  = ctrl.zy ? '0 : y;
    yc  = ctrl.ny ? ~yz : yz;
    res = ctrl.f ? (xc + yc) : (xc & yc);
    out = ctrl.no ? ~res : res;
    zr  = (out == '0);
    ng  = out[WIDTH-1];
  end

endmodule

// File: rtl/hack_cpu.sv
// Hack CPU core: one instruction per clock,
// A/D registers, ALU, jump logic driving the PC.
module hack_cpu
  import hack_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  instruction,
  input  logic [WIDTH-1:0]  inM,
  output logic [WIDTH-1:0]  outM,
  output logic              writeM,
  output logic [ADDR_W-1:0] addressM,
  output logic [ADDR_W-1:0] pc
);

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] alu_out;
  alu_ctrl_t        ctrl;
  logic             is_c;
  logic             zr;
  logic             ng;
  logic             jump;

  assign is_c = instruction[BIT_C];
  assign ctrl = instruction[CMP_HI:CMP_LO];
  assign y    = instruction[BIT_A] ? inM : a_reg;

  hack_alu u_alu (
    .x    (d_reg),
    .y    (y),
    .ctrl (ctrl),
    .out  (alu_out),
    .zr   (zr),
    .ng   (ng)
  );

  always_comb begin
    jump = is_c & (
      (instruction[BIT_JLT] & ng) |
      (instruction[BIT_JEQ] & zr) |
      (instruction[BIT_JGT] & ~ng & ~zr));
  end

  assign outM     = alu_out;
  assign writeM   = is_c & instruction[BIT_DM] & ~reset;
  assign addressM = a_reg[ADDR_W-1:0];
  assign pc       = pc_out[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (reset)
      a_reg <= '0;
    else if (!is_c)
      a_reg <= instruction;
    else if (instruction[BIT_DA])
      a_reg <= alu_out;
  end

  always_ff @(posedge clk) begin
    if (reset)
      d_reg <= '0;
    else if (is_c && instruction[BIT_DD])
      d_reg <= alu_out;
  end

  // Jump target is the pre-update A, even when A is a destination.
  PC u_pc (
    .clk   (clk),
    .reset (reset),
    .in    (a_reg),
    .load  (jump),
    .inc   (1'b1),
    .out   (pc_out)
  );

endmodule

// File: tb/tb_hack_cpu.sv
// Directed self-checking bench for hack_cpu.
module tb_hack_cpu;

  logic        clk;
  logic        reset;
  logic [15:0] instruction;
  logic [15:0] inM;
  logic [15:0] outM;
  logic        writeM;
  logic [14:0] addressM;
  logic [14:0] pc;

  int errors;
  int checks;

  hack_cpu dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .inM         (inM),
    .outM        (outM),
    .writeM      (writeM),
    .addressM    (addressM),
    .pc          (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [15:0] ins);
    instruction = ins;
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    inM = 16'h0000;
    instruction = 16'hE308;
    #1;
    chk("rst_writeM", {15'd0, writeM}, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_pc", {1'b0, pc}, 16'd0);
    chk("rst_addr", {1'b0, addressM}, 16'd0);

    step(16'h3039);
    chk("st_pc1", {1'b0, pc}, 16'd1);
    chk("st_addr1", {1'b0, addressM}, 16'h3039);
    step(16'hEC10);
    chk("st_pc2", {1'b0, pc}, 16'd2);
    step(16'h0002);
    chk("st_pc3", {1'b0, pc}, 16'd3);
    instruction = 16'hE308;
    #1;
    chk("st_outM", outM, 16'd12345);
    chk("st_writeM", {15'd0, writeM}, 16'd1);
    chk("st_addr", {1'b0, addressM}, 16'd2);
    step(16'hE308);
    chk("st_pc4", {1'b0, pc}, 16'd4);

    step(16'h0005);
    chk("ld_addr", {1'b0, addressM}, 16'd5);
    inM = 16'h7FFF;
    step(16'hFC10);
    inM = 16'h0000;
    instruction = 16'hE308;
    #1;
    chk("ld_outM", outM, 16'h7FFF);
    chk("ld_writeM", {15'd0, writeM}, 16'd1);
    step(16'hE308);
    chk("ld_pc", {1'b0, pc}, 16'd7);

    step(16'h3039);
    step(16'hEC10);
    step(16'h0064);
    step(16'hE301);
    chk("jgt_taken", {1'b0, pc}, 16'd100);
    step(16'hEA90);
    step(16'h0064);
    step(16'hE301);
    chk("jgt_fall", {1'b0, pc}, 16'd103);

    step(16'h7FFF);
    chk("wrap_addr", {1'b0, addressM}, 16'h7FFF);
    instruction = 16'hEA87;
    #1;
    chk("zero_outM", outM, 16'h0000);
    step(16'hEA87);
    chk("wrap_jmp", {1'b0, pc}, 16'h7FFF);
    step(16'h0000);
    chk("wrap_pc", {1'b0, pc}, 16'h0000);

    step(16'h0032);
    step(16'hEDE7);
    chk("adst_pc", {1'b0, pc}, 16'd50);
    chk("adst_addr", {1'b0, addressM}, 16'd51);
    step(16'hEEA0);
    chk("a15_addr", {1'b0, addressM}, 16'h7FFF);

    step(16'h3039);
    step(16'hEC10);
    step(16'h0002);
    reset = 1'b1;
    instruction = 16'hE308;
    #1;
    chk("mid_writeM", {15'd0, writeM}, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid_pc", {1'b0, pc}, 16'd0);
    chk("mid_addr", {1'b0, addressM}, 16'd0);
    instruction = 16'hE308;
    #1;
    chk("mid_D", outM, 16'h0000);
    chk("mid_wr", {15'd0, writeM}, 16'd1);
    step(16'hE308);
    step(16'hEC10);
    instruction = 16'hE308;
    #1;
    chk("mid_A", outM, 16'h0000);
    chk("mid_pc2", {1'b0, pc}, 16'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
